// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment digit scanner with per-slot anti-ghosting blank and frame-latched inputs.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_scan #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV        = 1000,
    parameter int unsigned BLANK      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [3:0]                num_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int unsigned           CW         = $clog2(DIV);
    localparam int unsigned           IW         = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0]         CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]         CNT_BLANK  = CW'(BLANK);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [3:0]            CODE_BLANK = 4'hF;
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t                       state_q;
    logic [CW-1:0]                cnt_q;
    logic [CW-1:0]                cnt_d;
    logic [IW-1:0]                idx_q;
    logic [IW-1:0]                idx_d;
    logic [NUM_DIGITS-1:0][3:0]   sh_dig_q;
    logic [NUM_DIGITS-1:0]        sh_dp_q;
    logic [NUM_DIGITS-1:0][3:0]   latch_dig_c;
    logic [NUM_DIGITS-1:0][3:0]   cur_dig_c;
    logic [NUM_DIGITS-1:0]        cur_dp_c;
    logic                         frame_start_c;
    logic                         slot_end_c;
    logic                         lit_c;

`ifdef SEG7_LZB_EN
    // Replace zeros above the most significant non-zero digit with the blank code; digit 0 always shows.
    always_comb begin : p_lzb
        logic zero_above;
        latch_dig_c = digits_in;
        zero_above  = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            if (zero_above && (digits_in[4*i +: 4] == 4'h0)) begin
                latch_dig_c[i] = CODE_BLANK;
            end else begin
                zero_above = 1'b0;
            end
        end
    end
`else
    assign latch_dig_c = digits_in;
`endif

    assign frame_start_c = (state_q == SCAN) && en && (cnt_q == '0) && (idx_q == '0);
    assign slot_end_c    = (cnt_q == CNT_LAST);
    assign lit_c         = (cnt_q >= CNT_BLANK);

    // With BLANK=0 the first slot must show the value being latched on this same edge.
    assign cur_dig_c = frame_start_c ? latch_dig_c : sh_dig_q;
    assign cur_dp_c  = frame_start_c ? dp_in       : sh_dp_q;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (slot_end_c) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_dig_q   <= '0;
            sh_dp_q    <= '0;
            num_out    <= CODE_BLANK;
            dp_out     <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            num_out    <= CODE_BLANK;
            dp_out     <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (en) begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!en) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        if (frame_start_c) begin
                            sh_dig_q <= latch_dig_c;
                            sh_dp_q  <= dp_in;
                        end
                        if (lit_c) begin
                            num_out <= cur_dig_c[idx_q];
                            dp_out  <= cur_dp_c[idx_q];
                            an      <= AN_ONE << idx_q;
                        end
                        frame_done <= slot_end_c && (idx_q == IDX_LAST);
                        cnt_q      <= cnt_d;
                        idx_q      <= idx_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
